// File: rtl/memory_ws.sv
// Single-port synchronous RAM with request/acknowledge handshake, programmable wait
// states and out-of-range flagging. Optional power-on clear sweep under MEM_CLEAR_EN.
module memory_ws #(
  parameter int DW          = 8,
  parameter int AW          = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          wre,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data,
  output logic          ready,
  output logic          ack,
  output logic          err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  if (WAIT_STATES < 0 || WAIT_STATES > 255) begin : g_bad_wait
    $error("memory_ws: WAIT_STATES must be in 0..255");
  end
  if (DEPTH < 1 || 64'(DEPTH) > (64'd1 << AW)) begin : g_bad_depth
    $error("memory_ws: DEPTH must be in 1..2**AW");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CLEAR} state_t;

  // Handshake: a request is accepted on any rising edge where ready=1 and ce=1;
  // addr/wre/in_data are captured then. ack pulses for one cycle when that access
  // completes, err is qualified by ack, and ready is already 1 during the ack cycle.
  state_t        state;
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [AW-1:0] addr_q;
  logic          wre_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] rd_q;
  logic [7:0]    cnt;
  logic          in_range;
  logic          done;
  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
`ifdef MEM_CLEAR_EN
  logic [IW-1:0] clr_addr;
`endif

  assign in_range = ({1'b0, addr_q} < DEPTH_W);
  assign done     = (state == S_WAIT) && (cnt == 8'd0);
  assign out_data = ce ? rd_q : {DW{1'bz}};

  // Memory write port is shared between normal writes and the clear sweep.
  always_comb begin
    mem_we    = done && wre_q && in_range;
    mem_waddr = addr_q[IW-1:0];
    mem_wdata = data_q;
`ifdef MEM_CLEAR_EN
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef MEM_CLEAR_EN
      state    <= S_CLEAR;
      ready    <= 1'b0;
      clr_addr <= '0;
`else
      state    <= S_IDLE;
      ready    <= 1'b1;
`endif
      ack    <= 1'b0;
      err    <= 1'b0;
      rd_q   <= '0;
      cnt    <= 8'd0;
      addr_q <= '0;
      wre_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ce) begin
            addr_q <= addr;
            wre_q  <= wre;
            data_q <= in_data;
            cnt    <= 8'(WAIT_STATES);
            ready  <= 1'b0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 8'd0) begin
            ack   <= 1'b1;
            err   <= !in_range;
            ready <= 1'b1;
            state <= S_IDLE;
            if (!wre_q) rd_q <= in_range ? mem[addr_q[IW-1:0]] : '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
`ifdef MEM_CLEAR_EN
        S_CLEAR: begin
          if (clr_addr == IW'(DEPTH - 1)) begin
            ready <= 1'b1;
            state <= S_IDLE;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
